// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and helper functions for the multichannel PWM block.
//   cnt_max(w)  : top count of a w-bit PWM counter (2^w - 2), so w'all-ones is 100 % duty.
//   ch_idx_w(n) : width of a channel index for n channels (never less than 1 bit).
//   duty_t      : duty word at the default 8-bit width; parameterised modules use logic [DUTY_W-1:0].
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;

  typedef logic [DUTY_W_DEF-1:0] duty_t;

  // The counter stops one short of all-ones so that a duty of all-ones
  // compares greater than every counter value and the output never drops.
  function automatic int cnt_max(input int duty_w);
    return (1 << duty_w) - 2;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus PWM period counter shared by all channels.
// Latency: cnt_o is registered; boundary_o is combinational in the wrap cycle; period_start_o is one clk later.
// Backpressure: none; free-running while enable_i is high, held at zero while it is low.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   enable_i        : run; low holds prescaler/counter at 0 and suppresses pulses
//   prescale_i      : tick every (prescale_i + 1) clocks
//   cnt_o           : current PWM counter value
//   boundary_o      : high in the cycle whose tick wraps the counter back to 0
//   period_start_o  : one-clk pulse in the first cycle the wrapped counter (0) is visible
//
// Build option: define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned)
// counter with a direction flag; without it the counter is edge-aligned.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [DUTY_W-1:0]     cnt_o,
  output logic                  boundary_o,
  output logic                  period_start_o
);

  localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(cnt_max(DUTY_W));

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [DUTY_W-1:0]     cnt_q, cnt_d;
  logic                  period_start_q;
  logic                  tick;
  logic                  boundary;
`ifdef PWM_CENTER_ALIGN_EN
  logic                  dir_down_q, dir_down_d;
`endif

  // Prescaler. The >= compare lets a reduced prescale value take effect on
  // the very next clock instead of waiting for the counter to run past it.
  always_comb begin
    tick   = enable_i && (pcnt_q >= prescale_i);
    pcnt_d = '0;
    if (enable_i && !tick) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  // Up/down counter: 0 .. MAX .. 1, 0 .. The period boundary is the tick that
  // brings the down-count from 1 to 0, so pulses straddle the boundary.
  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    boundary   = 1'b0;
    if (!enable_i) begin
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else if (tick) begin
      if (!dir_down_q) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d      = cnt_q - DUTY_W'(1);
          dir_down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DUTY_W'(1);
        end
      end else begin
        cnt_d = cnt_q - DUTY_W'(1);
        if (cnt_q == DUTY_W'(1)) begin
          dir_down_d = 1'b0;
          boundary   = 1'b1;
        end
      end
    end
  end
`else
  // Edge-aligned counter: 0 .. MAX, then wrap to 0 on the boundary tick.
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q + DUTY_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q         <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down_q     <= 1'b0;
`endif
    end else begin
      pcnt_q         <= pcnt_d;
      cnt_q          <= cnt_d;
      // boundary can only be set by a tick, which already implies enable_i.
      period_start_q <= boundary;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down_q     <= dir_down_d;
`endif
    end
  end

  assign cnt_o          = cnt_q;
  assign boundary_o     = boundary;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_multichan.sv
// pwm_multichan: N-channel PWM generator with double-buffered duty registers.
// Latency: pwm_out is registered, one clk after the counter value it reflects; duty writes land in the shadow next clk.
// Backpressure: none; the write port accepts a write every clock, writes to a non-existent channel are dropped.
//
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   enable         : global run; low blanks all outputs and stops the time base
//   prescale       : PWM tick = clk / (prescale + 1)
//   duty_wr_en     : single-cycle shadow duty write strobe
//   duty_wr_ch     : channel index for the write
//   duty_wr_data   : new duty value
//   period_start   : one-clk pulse at every period boundary
//   pwm_out        : PWM outputs, bit i is channel i
//
// Build option: PWM_CENTER_ALIGN_EN selects the centre-aligned time base.
module pwm_multichan
  import pwm_pkg::*;
#(
  parameter  int NUM_CH     = 6,
  parameter  int DUTY_W     = 8,
  parameter  int PRESCALE_W = 16,
  localparam int CH_IDX_W   = ch_idx_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  duty_wr_en,
  input  logic [CH_IDX_W-1:0]   duty_wr_ch,
  input  logic [DUTY_W-1:0]     duty_wr_data,
  output logic                  period_start,
  output logic [NUM_CH-1:0]     pwm_out
);

  logic [DUTY_W-1:0] shadow_q [NUM_CH];
  logic [DUTY_W-1:0] shadow_d [NUM_CH];
  logic [DUTY_W-1:0] active_q [NUM_CH];
  logic [DUTY_W-1:0] active_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [DUTY_W-1:0] cnt;
  logic              boundary;

  pwm_timebase #(
    .DUTY_W     (DUTY_W),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk_i          (clk),
    .rst_ni         (resetn),
    .enable_i       (enable),
    .prescale_i     (prescale),
    .cnt_o          (cnt),
    .boundary_o     (boundary),
    .period_start_o (period_start)
  );

  // Active duty loads from the post-write shadow value, so a write landing
  // in the boundary cycle goes straight into the new period. While disabled
  // the active copy follows the shadow so a restart uses the latest duties.
  // Matching the index per channel makes out-of-range indices a no-op.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (duty_wr_en && (duty_wr_ch == CH_IDX_W'(i))) begin
        shadow_d[i] = duty_wr_data;
      end
      active_d[i] = (!enable || boundary) ? shadow_d[i] : active_q[i];
      pwm_d[i]    = enable && (cnt < active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multichan.sv
// tb_pwm_multichan: directed stimulus with a period-position reference model
// compared every clock, plus hand-computed high-time and period checks.
module tb_pwm_multichan;

  localparam int NUM_CH     = 6;
  localparam int DUTY_W     = 8;
  localparam int PRESCALE_W = 16;
  localparam int CH_IDX_W   = 3;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int MAXC   = (1 << DUTY_W) - 2;
  localparam int PERIOD = 2 * MAXC;
`else
  localparam int PERIOD = (1 << DUTY_W) - 1;
`endif

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic                  duty_wr_en;
  logic [CH_IDX_W-1:0]   duty_wr_ch;
  logic [DUTY_W-1:0]     duty_wr_data;
  logic                  period_start;
  logic [NUM_CH-1:0]     pwm_out;

  always #5 clk = ~clk;

  pwm_multichan #(
    .NUM_CH     (NUM_CH),
    .DUTY_W     (DUTY_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .prescale     (prescale),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_ch   (duty_wr_ch),
    .duty_wr_data (duty_wr_data),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the position inside the period (ticks since the boundary) and
  // derives the counter value from it arithmetically.
  int m_pcnt = 0;
  int m_pos  = 0;
  int m_sh  [NUM_CH] = '{default: 0};
  int m_act [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] exp_pwm = '0;
  logic              exp_ps  = 1'b0;

  function automatic int cnt_at(input int pos);
`ifdef PWM_CENTER_ALIGN_EN
    return (pos <= MAXC) ? pos : PERIOD - pos;
`else
    return pos;
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    int nsh [NUM_CH];
    bit tick;
    bit bnd;
    int c;
    if (!resetn) begin
      m_pcnt = 0;
      m_pos  = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh[i]  = 0;
        m_act[i] = 0;
      end
      exp_pwm = '0;
      exp_ps  = 1'b0;
    end else begin
      tick = enable && (m_pcnt >= int'(prescale));
      c    = cnt_at(m_pos);
      bnd  = tick && (m_pos == PERIOD - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        nsh[i] = m_sh[i];
        if (duty_wr_en && int'(duty_wr_ch) == i) nsh[i] = int'(duty_wr_data);
        exp_pwm[i] = enable && (c < m_act[i]);
      end
      exp_ps = bnd;
      if (!enable) begin
        m_pcnt = 0;
        m_pos  = 0;
      end else begin
        m_pcnt = tick ? 0 : m_pcnt + 1;
        if (tick) m_pos = (m_pos + 1) % PERIOD;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable || bnd) m_act[i] = nsh[i];
        m_sh[i] = nsh[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pwm_out vs model", int'(pwm_out), int'(exp_pwm));
      chk("period_start vs model", int'(period_start), int'(exp_ps));
    end
  end

  // ---------------- stimulus helpers (all driven at negedges) ----------------
  int   hi [NUM_CH];
  int   ps_n;
  logic ps_last;
  int   fall_k, rise_k, n_rise;

  task automatic wr(input int ch, input int d);
    duty_wr_en   = 1'b1;
    duty_wr_ch   = CH_IDX_W'(ch);
    duty_wr_data = DUTY_W'(d);
    @(negedge clk);
    duty_wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < bound);
    chk("period_start within bound", int'(period_start), 1);
  endtask

  // Counts high cycles per channel over len negedges; optionally issues a
  // write at iteration wr_at (sampled by the following posedge).
  task automatic count_window(input int len, input int wr_at, input int wr_ch, input int wr_data);
    logic prev;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    ps_n   = 0;
    fall_k = -1;
    rise_k = -1;
    n_rise = 0;
    prev   = pwm_out[0];
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
      if (period_start) ps_n++;
      if (pwm_out[0] && !prev) begin
        n_rise++;
        rise_k = k;
      end
      if (!pwm_out[0] && prev) fall_k = k;
      prev = pwm_out[0];
      if (k == wr_at) begin
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_IDX_W'(wr_ch);
        duty_wr_data = DUTY_W'(wr_data);
      end else begin
        duty_wr_en = 1'b0;
      end
    end
    ps_last = period_start;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int n;
    int nz;
    int psc;
    resetn       = 1'b0;
    enable       = 1'b0;
    prescale     = '0;
    duty_wr_en   = 1'b0;
    duty_wr_ch   = '0;
    duty_wr_data = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;

    // 1. reset and defaults
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset period_start", int'(period_start), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("reset held with enable pwm_out", int'(pwm_out), 0);
    resetn = 1'b1;
    wait_ps(3 * PERIOD, n);
    chk("t1 first period length", n, PERIOD);
    for (int p = 0; p < 3; p++) begin
      count_window(PERIOD, -1, 0, 0);
      nz = 0;
      for (int i = 0; i < NUM_CH; i++) nz += hi[i];
      chk("t1 outputs low", nz, 0);
      chk("t1 one pulse per period", ps_n, 1);
      chk("t1 pulse ends period", int'(ps_last), 1);
    end

`ifndef PWM_CENTER_ALIGN_EN
    // 2. duty accuracy
    wr(0, 64);
    wr(1, 255);
    wr(2, 0);
    wait_ps(600, n);
    count_window(255, -1, 0, 0);
    chk("t2 ch0 high clks", hi[0], 64);
    chk("t2 ch1 high clks", hi[1], 255);
    chk("t2 ch2 high clks", hi[2], 0);
    chk("t2 period 255", int'(ps_last), 1);

    // 3. glitch-free update mid-period
    wr(0, 128);
    wait_ps(600, n);
    count_window(255, 99, 0, 10);
    chk("t3 current period ch0", hi[0], 128);
    count_window(255, -1, 0, 0);
    chk("t3 next period ch0", hi[0], 10);

    // 4. boundary bypass and out-of-range channel
    count_window(255, 253, 3, 200);
    chk("t4 ch3 before boundary", hi[3], 0);
    chk("t4 boundary at window end", int'(ps_last), 1);
    count_window(255, 50, 7, 33);
    chk("t4 ch3 bypassed period", hi[3], 200);
    chk("t4 ch0 unchanged", hi[0], 10);
    count_window(255, -1, 0, 0);
    chk("t4 illegal ch0", hi[0], 10);
    chk("t4 illegal ch1", hi[1], 255);
    chk("t4 illegal ch2", hi[2], 0);
    chk("t4 illegal ch3", hi[3], 200);
    chk("t4 illegal ch4", hi[4], 0);
    chk("t4 illegal ch5", hi[5], 0);

    // 5. prescale and enable
    prescale = PRESCALE_W'(3);
    wait_ps(3000, n);
    count_window(1020, -1, 0, 0);
    chk("t5 one pulse in 1020", ps_n, 1);
    chk("t5 period 1020", int'(ps_last), 1);
    chk("t5 ch0 high clks", hi[0], 40);
    chk("t5 ch1 high clks", hi[1], 1020);
    chk("t5 ch3 high clks", hi[3], 800);
    count_window(300, -1, 0, 0);
    enable = 1'b0;
    nz  = 0;
    psc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pwm_out != '0) nz++;
      if (period_start) psc++;
      if (k == 0) begin
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_IDX_W'(4);
        duty_wr_data = DUTY_W'(77);
      end else begin
        duty_wr_en = 1'b0;
      end
    end
    chk("t5 disabled outputs low", nz, 0);
    chk("t5 disabled no period_start", psc, 0);
    enable = 1'b1;
    count_window(1020, -1, 0, 0);
    chk("t5 restart period 1020", int'(ps_last), 1);
    chk("t5 restart single pulse", ps_n, 1);
    chk("t5 restart ch4 from shadow", hi[4], 308);
    chk("t5 restart ch0", hi[0], 40);
`else
    // 6. centre-aligned build
    wr(0, 50);
    wait_ps(1200, n);
    count_window(508, -1, 0, 0);
    chk("t6 period 508", int'(ps_last), 1);
    chk("t6 one pulse", ps_n, 1);
    chk("t6 ch0 high clks", hi[0], 99);
    chk("t6 ch0 contiguous", n_rise, 1);
    chk("t6 ch0 falls after boundary", fall_k, 50);
    chk("t6 ch0 rises before boundary", rise_k, 459);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
